hsci_regmap_arbiter: RTL and testbench

Shares the single HSCI master register-map access port (rd_addr / wr_stb / wr_addr / wr_data / read_data) between two requesters: requester 0 (AXI-Lite bridge) and requester 1 (local init/run sequencer).
- Serialises accesses with round-robin arbitration.
- Sequences each access into the register map's one-cycle registered read timing.
- Returns read data with a one-cycle ack pulse.
- Sits between the requesters and hsci_master_logic.

---
 rtl/hsci_regmap_arb_pkg.sv | 16 +
 rtl/hsci_rr_arb2.sv | 20 ++
 rtl/hsci_regmap_arbiter.sv | 146 ++++++++++++++
 tb/tb_hsci_regmap_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsci_regmap_arb_pkg.sv
// Shared types and constants for the HSCI register-map arbiter.
// Holds the arbiter state encoding and the requester indices.
package hsci_regmap_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_t;

    localparam int NUM_REQ = 2;
    localparam int REQ_AXI = 0;
    localparam int REQ_SEQ = 1;

endpackage

// File: rtl/hsci_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// The requester that did not win last time gets priority on a tie.
module hsci_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    // pick a one-hot winner; on a tie favour the one that is not 'last'
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/hsci_regmap_arbiter.sv
// Shares the HSCI register-map access port between two requesters.
// Each grant runs IDLE -> ISSUE -> WAIT -> ACK with registered outputs.
module hsci_regmap_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic                  reg_wr_stb,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  busy,
    output logic [1:0]            grant
);

    import hsci_regmap_arb_pkg::*;

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic                  last;
    logic [1:0]            win;
    logic                  lat_wr;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  take;

    hsci_rr_arb2 u_rr (
        .req  ({m1_req, m0_req}),
        .last (last),
        .win  (win)
    );

    assign take = (state == IDLE) && (win != 2'b00);

    // route the winning requester's fields
    always_comb begin
        sel_wr    = m0_wr;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (win[REQ_SEQ]) begin
            sel_wr    = m1_wr;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    // next-state logic; every non-idle state lasts one cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // remember the access type and who was served last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wr <= 1'b0;
            last   <= 1'b1;
        end else if (take) begin
            lat_wr <= sel_wr;
            last   <= win[REQ_SEQ];
        end
    end

    // registered regmap port, grant/busy, acks and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rd_addr <= '0;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            busy        <= 1'b0;
            grant       <= 2'b00;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            reg_wr_stb <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        grant       <= win;
                        busy        <= 1'b1;
                        reg_rd_addr <= sel_addr;
                        if (sel_wr) begin
                            reg_wr_stb  <= 1'b1;
                            reg_wr_addr <= sel_addr;
                            reg_wr_data <= sel_wdata;
                        end
                    end
                end
                ISSUE: begin
                end
                WAIT: begin
                    if (grant[REQ_AXI]) begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= lat_wr ? '0 : reg_rd_data;
                    end
                    if (grant[REQ_SEQ]) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= lat_wr ? '0 : reg_rd_data;
                    end
                end
                ACK: begin
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsci_regmap_arbiter.sv
// Scoreboard bench for hsci_regmap_arbiter with a regmap model,
// two requester drivers and a transaction-level reference model.
module tb_hsci_regmap_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req0 = 1'b0, wr0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] wdata0 = '0;
    logic          req1 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] reg_rd_addr, reg_wr_addr;
    logic          reg_wr_stb;
    logic [DW-1:0] reg_wr_data, reg_rd_data;
    logic          busy;
    logic [1:0]    grant;

    hsci_regmap_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (req0),
        .m0_wr       (wr0),
        .m0_addr     (addr0),
        .m0_wdata    (wdata0),
        .m0_ack      (m0_ack),
        .m0_rdata    (m0_rdata),
        .m1_req      (req1),
        .m1_wr       (wr1),
        .m1_addr     (addr1),
        .m1_wdata    (wdata1),
        .m1_ack      (m1_ack),
        .m1_rdata    (m1_rdata),
        .reg_rd_addr (reg_rd_addr),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .grant       (grant)
    );

    // register map: write on strobe, registered read of rd_addr
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (reg_wr_stb) mem[reg_wr_addr] <= reg_wr_data;
        reg_rd_data <= mem[reg_rd_addr];
    end

    function automatic logic [DW-1:0] init_val(int i);
        return 32'hA500_0000 ^ 32'(i * 32'h0001_0203);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            gap;
    } op_t;
    typedef struct {
        int            id;
        logic [DW-1:0] d;
        int            c;
    } ack_t;
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } wexp_t;

    op_t   q0[$], q1[$];
    ack_t  ack_q[$];
    wexp_t wr_q[$];
    bit    pend0 = 0, pend1 = 0;
    int    tmo0 = 0, tmo1 = 0, dtmo = 0;
    bit    done = 0, fin = 0;

    // reference model: one access at a time, ack three cycles after
    // the sampling cycle, next sample four cycles later, round robin
    logic [DW-1:0] mmem [1024];
    int            m_last = 1, m_free = 0, m_own = -1, m_start = 0;
    logic [AW-1:0] m_addr = '0;

    always @(posedge clk or posedge rst) begin : model
        int            w;
        logic          mw;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        ack_t          e;
        wexp_t         we;
        if (rst) begin
            m_last = 1;
            m_free = 0;
            m_own  = -1;
            ack_q.delete();
            wr_q.delete();
        end else if (cyc >= m_free && (req0 || req1)) begin
            if (req0 && req1) w = (m_last == 0) ? 1 : 0;
            else w = req1 ? 1 : 0;
            mw = w ? wr1 : wr0;
            ma = w ? addr1 : addr0;
            md = w ? wdata1 : wdata0;
            m_last  = w;
            m_own   = w;
            m_start = cyc + 1;
            m_free  = cyc + 4;
            m_addr  = ma;
            e.id = w;
            e.c  = cyc + 3;
            if (mw) begin
                mmem[ma] = md;
                we.a = ma;
                we.d = md;
                we.c = cyc + 1;
                wr_q.push_back(we);
                e.d = '0;
            end else begin
                e.d = mmem[ma];
            end
            ack_q.push_back(e);
        end
    end

    // requester 0 driver
    initial begin : drv0
        op_t op;
        int  n;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() == 0) begin
                req0 = 1'b0;
            end else begin
                op = q0.pop_front();
                pend0 = 1;
                if (op.gap > 0) begin
                    req0 = 1'b0;
                    repeat (op.gap) @(posedge clk);
                    #1;
                end
                wr0 = op.wr; addr0 = op.a; wdata0 = op.d; req0 = 1'b1;
                n = 0;
                do begin @(negedge clk); n++; end while (!m0_ack && n < 40);
                if (!m0_ack) begin tmo0++; req0 = 1'b0; end
                pend0 = 0;
            end
        end
    end

    // requester 1 driver
    initial begin : drv1
        op_t op;
        int  n;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() == 0) begin
                req1 = 1'b0;
            end else begin
                op = q1.pop_front();
                pend1 = 1;
                if (op.gap > 0) begin
                    req1 = 1'b0;
                    repeat (op.gap) @(posedge clk);
                    #1;
                end
                wr1 = op.wr; addr1 = op.a; wdata1 = op.d; req1 = 1'b1;
                n = 0;
                do begin @(negedge clk); n++; end while (!m1_ack && n < 40);
                if (!m1_ack) begin tmo1++; req1 = 1'b0; end
                pend1 = 0;
            end
        end
    end

    // monitor / scoreboard
    int            comp = 0, mism = 0;
    logic [DW-1:0] hold0 = '0, hold1 = '0;

    always @(negedge clk) begin : mon
        logic [1:0]    eg;
        logic          ak;
        logic [DW-1:0] rd, hd;
        ack_t          a;
        wexp_t         w;
        if (rst) begin
            hold0 = '0;
            hold1 = '0;
            comp++;
            if ({m0_ack, m1_ack, m0_rdata, m1_rdata, reg_rd_addr, reg_wr_stb,
                 reg_wr_addr, reg_wr_data, busy, grant} !== '0) begin
                mism++;
                $display("FAIL reset_outputs cyc=%0d got ack=%b%b busy=%b grant=%b stb=%b rd_addr=%h rdata0=%h required all zero",
                         cyc, m1_ack, m0_ack, busy, grant, reg_wr_stb, reg_rd_addr, m0_rdata);
            end
        end else begin
            eg = (m_own >= 0 && cyc >= m_start && cyc <= m_start + 2)
                 ? 2'(1 << m_own) : 2'b00;
            comp++;
            if (grant !== eg || busy !== (eg != 2'b00)) begin
                mism++;
                $display("FAIL grant_busy cyc=%0d got grant=%b busy=%b required grant=%b busy=%b",
                         cyc, grant, busy, eg, eg != 2'b00);
            end
            if (m_own >= 0 && cyc == m_start) begin
                comp++;
                if (reg_rd_addr !== m_addr) begin
                    mism++;
                    $display("FAIL issue_rd_addr cyc=%0d got %h required %h", cyc, reg_rd_addr, m_addr);
                end
            end
            if (wr_q.size() != 0 && wr_q[0].c <= cyc && !(reg_wr_stb && wr_q[0].c == cyc)) begin
                w = wr_q.pop_front();
                comp++;
                mism++;
                $display("FAIL wr_stb_missing cyc=%0d got stb=0 required stb=1 at cyc %0d", cyc, w.c);
            end
            if (reg_wr_stb) begin
                comp++;
                if (wr_q.size() == 0 || wr_q[0].c != cyc) begin
                    mism++;
                    $display("FAIL wr_stb_unexpected cyc=%0d got stb=1 required stb=0", cyc);
                end else begin
                    w = wr_q.pop_front();
                    if (reg_wr_addr !== w.a || reg_wr_data !== w.d) begin
                        mism++;
                        $display("FAIL wr_fields cyc=%0d got %h/%h required %h/%h",
                                 cyc, reg_wr_addr, reg_wr_data, w.a, w.d);
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                ak = (i == 1) ? m1_ack : m0_ack;
                rd = (i == 1) ? m1_rdata : m0_rdata;
                hd = (i == 1) ? hold1 : hold0;
                comp++;
                if (ak) begin
                    if (ack_q.size() == 0) begin
                        mism++;
                        $display("FAIL ack_unexpected cyc=%0d req=%0d got ack=1 required ack=0", cyc, i);
                    end else begin
                        a = ack_q.pop_front();
                        if (a.id != i || a.c != cyc || a.d !== rd) begin
                            mism++;
                            $display("FAIL ack cyc=%0d got req=%0d rdata=%h required req=%0d cyc=%0d rdata=%h",
                                     cyc, i, rd, a.id, a.c, a.d);
                        end
                        if (i == 1) hold1 = a.d;
                        else hold0 = a.d;
                    end
                end else if (rd !== hd) begin
                    mism++;
                    $display("FAIL rdata_hold cyc=%0d req=%0d got %h required %h", cyc, i, rd, hd);
                end
            end
            if (ack_q.size() != 0 && ack_q[0].c < cyc) begin
                a = ack_q.pop_front();
                comp++;
                mism++;
                $display("FAIL ack_missing cyc=%0d req=%0d got no ack required ack at cyc %0d", cyc, a.id, a.c);
            end
        end
        if (done && !fin) begin
            fin = 1;
            comp++;
            if (ack_q.size() != 0 || wr_q.size() != 0) begin
                mism++;
                $display("FAIL leftover got %0d acks %0d writes pending required 0",
                         ack_q.size(), wr_q.size());
            end
            comp++;
            if (tmo0 != 0 || tmo1 != 0 || dtmo != 0) begin
                mism++;
                $display("FAIL timeout got tmo0=%0d tmo1=%0d drain=%0d required 0", tmo0, tmo1, dtmo);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, mism);
            $finish;
        end
    end

    task automatic push(input int id, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap);
        op_t o;
        o.wr = wr; o.a = a; o.d = d; o.gap = gap;
        if (id == 1) q1.push_back(o);
        else q0.push_back(o);
    endtask

    task automatic drain();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || pend0 || pend1) && k < 600) begin
            @(posedge clk);
            k++;
        end
        if (k >= 600) dtmo++;
        repeat (4) @(posedge clk);
        #2;
    endtask

    initial begin : main
        int k;
        int a;
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = init_val(i);
            mmem[i] = init_val(i);
        end
        mem[16]  = 32'hDEAD_BEEF;
        mmem[16] = 32'hDEAD_BEEF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // simultaneous requests right after reset, both held high
        push(0, 1'b0, 10'h020, '0, 0);
        push(0, 1'b1, 10'h021, 32'h1111_0000, 0);
        push(1, 1'b1, 10'h022, 32'h2222_0000, 0);
        push(1, 1'b0, 10'h020, '0, 0);
        drain();

        // single read and single write
        push(0, 1'b0, 10'h010, '0, 0);
        drain();
        push(1, 1'b1, 10'h004, 32'h0000_0001, 0);
        drain();

        // m0 streams back-to-back, m1 joins mid-stream
        for (int i = 0; i < 4; i++)
            push(0, 1'($urandom_range(0, 1)), 10'(i + 8), $urandom, 0);
        repeat (6) @(posedge clk);
        #2;
        push(1, 1'b0, 10'h009, '0, 0);
        drain();

        // write then read of the same address
        push(1, 1'b1, 10'h004, 32'h0000_0001, 0);
        @(posedge clk);
        #2;
        push(0, 1'b0, 10'h004, '0, 0);
        drain();

        // reset during WAIT of an m0 read, req stays high
        push(0, 1'b0, 10'h010, '0, 0);
        k = 0;
        do begin @(posedge clk); #2; k++; end while (!req0 && k < 20);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        drain();

        // randomized traffic on a small address set
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 12; i++) begin
                a = int'($urandom_range(0, 8));
                push(r, 1'($urandom_range(0, 1)), (a == 8) ? 10'h010 : 10'(a), $urandom,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end
        drain();

        done = 1;
        repeat (20) @(posedge clk);
        $fatal(1, "FAIL summary not reached");
    end

endmodule
